uart_cmd_parser: RTL and testbench

//   Consumes the received-byte stream of the UART receiver (one-cycle rvalid strobe + 8-bit rdata,
//   no backpressure) and parses ASCII command lines into bus requests. Grammar per line:
//   "W <addr> <data>" or "R <addr>", then CR or LF. Sits between the UART RX stage and the

---
 rtl/uart_cmd_parser.sv | 218 +++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns the UART RX byte stream into bus requests.
// Accepted lines are "W <addr> <data>" or "R <addr>", each ended by CR or LF.
// Each well-formed line produces one request, which is held on a valid/ready
// handshake. A malformed line raises a one-cycle err pulse. A byte that arrives
// while a request is still pending is dropped and raises a one-cycle ovf pulse.
module uart_cmd_parser #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rvalid_i,
    input  logic [7:0]        rdata_i,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic              cmd_write_o,
    output logic [ADDR_W-1:0] cmd_addr_o,
    output logic [DATA_W-1:0] cmd_wdata_o,
    output logic              err_o,
    output logic              ovf_o
);

    localparam int NA    = ADDR_W / 4;
    localparam int ND    = DATA_W / 4;
    localparam int MAXD  = (NA > ND) ? NA : ND;
    localparam int CNT_W = $clog2(MAXD + 1);

    localparam logic [CNT_W-1:0] NA_C  = CNT_W'(NA);
    localparam logic [CNT_W-1:0] ND_C  = CNT_W'(ND);
    localparam logic [CNT_W-1:0] CNT_0 = '0;
    localparam logic [CNT_W-1:0] CNT_1 = CNT_W'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEP   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_TAIL  = 3'd4;
    localparam logic [2:0] S_SKIP  = 3'd5;
    localparam logic [2:0] S_ISSUE = 3'd6;

    logic [2:0]        state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;

    logic       isHex, isSp, isTerm, isW, isR;
    logic [3:0] nibble;

    // Classify the incoming byte and convert hex digits to their nibble value
    always_comb begin
        isHex  = 1'b0;
        nibble = 4'd0;
        isSp   = (rdata_i == 8'h20);
        isTerm = (rdata_i == 8'h0D) || (rdata_i == 8'h0A);
        isW    = (rdata_i == 8'h57) || (rdata_i == 8'h77);
        isR    = (rdata_i == 8'h52) || (rdata_i == 8'h72);
        if (rdata_i >= 8'h30 && rdata_i <= 8'h39) begin
            isHex  = 1'b1;
            nibble = rdata_i[3:0];
        end else if ((rdata_i >= 8'h41 && rdata_i <= 8'h46) ||
                     (rdata_i >= 8'h61 && rdata_i <= 8'h66)) begin
            isHex  = 1'b1;
            nibble = rdata_i[3:0] + 4'd9;
        end
    end

    // Line parser: advances only on received bytes, except while a request is pending
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        ovf_d   = 1'b0;
        if (state_q == S_ISSUE) begin
            ovf_d = rvalid_i;
            if (valid_q && cmd_ready_i) begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        end else if (rvalid_i) begin
            case (state_q)
                S_IDLE: begin
                    if (isSp || isTerm) begin
                        state_d = S_IDLE;
                    end else if (isW || isR) begin
                        state_d = S_SEP;
                        write_d = isW;
                        addr_d  = '0;
                        wdata_d = '0;
                    end else begin
                        state_d = S_SKIP;
                    end
                end
                S_SEP: begin
                    if (isSp) begin
                        state_d = S_ADDR;
                        addr_d  = '0;
                        cnt_d   = CNT_0;
                    end else if (isTerm) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_SKIP;
                    end
                end
                S_ADDR: begin
                    if (isSp) begin
                        if (cnt_q != CNT_0) begin
                            if (write_q) begin
                                state_d = S_DATA;
                                wdata_d = '0;
                                cnt_d   = CNT_0;
                            end else begin
                                state_d = S_TAIL;
                            end
                        end
                    end else if (isHex) begin
                        if (cnt_q < NA_C) begin
                            addr_d = (addr_q << 4) | ADDR_W'(nibble);
                            cnt_d  = cnt_q + CNT_1;
                        end else begin
                            state_d = S_SKIP;
                        end
                    end else if (isTerm) begin
                        if (cnt_q != CNT_0 && !write_q) begin
                            state_d = S_ISSUE;
                            valid_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                        end
                    end else begin
                        state_d = S_SKIP;
                    end
                end
                S_DATA: begin
                    if (isSp) begin
                        if (cnt_q != CNT_0) begin
                            state_d = S_TAIL;
                        end
                    end else if (isHex) begin
                        if (cnt_q < ND_C) begin
                            wdata_d = (wdata_q << 4) | DATA_W'(nibble);
                            cnt_d   = cnt_q + CNT_1;
                        end else begin
                            state_d = S_SKIP;
                        end
                    end else if (isTerm) begin
                        if (cnt_q != CNT_0) begin
                            state_d = S_ISSUE;
                            valid_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                        end
                    end else begin
                        state_d = S_SKIP;
                    end
                end
                S_TAIL: begin
                    if (isTerm) begin
                        state_d = S_ISSUE;
                        valid_d = 1'b1;
                    end else if (!isSp) begin
                        state_d = S_SKIP;
                    end
                end
                S_SKIP: begin
                    if (isTerm) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset abandons any partial line or pending request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= CNT_0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign cmd_valid_o = valid_q;
    assign cmd_write_o = write_q;
    assign cmd_addr_o  = addr_q;
    assign cmd_wdata_o = wdata_q;
    assign err_o       = err_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed scenarios for the UART command-line parser.
module tb_uart_cmd_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rvalid = 1'b0;
    logic [7:0]  rdata = 8'h00;
    logic        cmdReady = 1'b0;
    logic        cmdValid, cmdWrite, errPulse, ovfPulse;
    logic [15:0] cmdAddr;
    logic [31:0] cmdWdata;

    int checks = 0;
    int errors = 0;

    int errCount = 0;
    int ovfCount = 0;
    int validCycles = 0;
    int hsCount = 0;
    int stableViol = 0;
    logic        hsWrite = 1'b0;
    logic [15:0] hsAddr = '0;
    logic [31:0] hsWdata = '0;
    logic        prevValid = 1'b0;
    logic        prevWrite = 1'b0;
    logic [15:0] prevAddr = '0;
    logic [31:0] prevWdata = '0;

    uart_cmd_parser #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rvalid_i    (rvalid),
        .rdata_i     (rdata),
        .cmd_valid_o (cmdValid),
        .cmd_ready_i (cmdReady),
        .cmd_write_o (cmdWrite),
        .cmd_addr_o  (cmdAddr),
        .cmd_wdata_o (cmdWdata),
        .err_o       (errPulse),
        .ovf_o       (ovfPulse)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Mid-cycle monitor: counts pulse cycles, handshakes, and field changes while valid
    always @(negedge clk) begin
        if (errPulse) errCount++;
        if (ovfPulse) ovfCount++;
        if (cmdValid) validCycles++;
        if (cmdValid && cmdReady) begin
            hsCount++;
            hsWrite = cmdWrite;
            hsAddr  = cmdAddr;
            hsWdata = cmdWdata;
        end
        if (cmdValid && prevValid &&
            (cmdWrite != prevWrite || cmdAddr != prevAddr || cmdWdata != prevWdata))
            stableViol++;
        prevValid = cmdValid;
        prevWrite = cmdWrite;
        prevAddr  = cmdAddr;
        prevWdata = cmdWdata;
    end

    // Safety net so the run can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Present one byte for one cycle, then idle for gap cycles; call at posedge+1
    task automatic sendByte(input logic [7:0] b, input int gap);
        rdata  = b;
        rvalid = 1'b1;
        @(posedge clk); #1;
        rvalid = 1'b0;
        rdata  = 8'h00;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    // Send every character of a string with the given inter-byte gap
    task automatic sendString(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) sendByte(s[i], gap);
    endtask

    // Hold reset and check that every output comes up zero
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cmdValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b want 0", cmdValid); end
        checks++; if (cmdWrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_write: got %0b want 0", cmdWrite); end
        checks++; if (cmdAddr !== 16'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h want 0000", cmdAddr); end
        checks++; if (cmdWdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata: got %h want 0", cmdWdata); end
        checks++; if ({errPulse, ovfPulse} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b want 00", {errPulse, ovfPulse}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Write line with mixed-case hex, checking the one-cycle latency after the terminator
    task automatic test_write;
        int hs0, err0, vc0;
        hs0 = hsCount; err0 = errCount; vc0 = validCycles;
        cmdReady = 1'b1;
        sendString("W 1A2b DEADbeef", 10);
        checks++; if (cmdValid !== 1'b0) begin errors++; $display("[TB] FAIL write_early_valid: got %0b want 0", cmdValid); end
        sendByte(8'h0A, 0);
        checks++; if (cmdValid !== 1'b1) begin errors++; $display("[TB] FAIL write_latency: got %0b want 1", cmdValid); end
        checks++; if (cmdWrite !== 1'b1) begin errors++; $display("[TB] FAIL write_flag: got %0b want 1", cmdWrite); end
        checks++; if (cmdAddr !== 16'h1A2B) begin errors++; $display("[TB] FAIL write_addr: got %h want 1a2b", cmdAddr); end
        checks++; if (cmdWdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL write_wdata: got %h want deadbeef", cmdWdata); end
        repeat (10) @(posedge clk);
        #1;
        checks++; if (hsCount - hs0 !== 1) begin errors++; $display("[TB] FAIL write_hs: got %0d want 1", hsCount - hs0); end
        checks++; if (validCycles - vc0 !== 1) begin errors++; $display("[TB] FAIL write_valid_width: got %0d want 1", validCycles - vc0); end
        // Full-width fields and runs of separating spaces
        sendString("W FFFF FFFFFFFF\n", 10);
        checks++; if (hsAddr !== 16'hFFFF || hsWdata !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL write_full: got %h/%h want ffff/ffffffff", hsAddr, hsWdata); end
        sendString("w  5  7 \r", 10);
        checks++; if (hsAddr !== 16'h0005 || hsWdata !== 32'h7 || hsWrite !== 1'b1) begin errors++; $display("[TB] FAIL write_spaces: got %h/%h/%0b want 0005/00000007/1", hsAddr, hsWdata, hsWrite); end
        checks++; if (hsCount - hs0 !== 3 || errCount - err0 !== 0) begin errors++; $display("[TB] FAIL write_totals: got hs=%0d err=%0d want 3/0", hsCount - hs0, errCount - err0); end
    endtask

    // Read held by a slow consumer: stable for 21 cycles, CR then LF gives no error
    task automatic test_read_hold;
        int hs0, err0, ovf0, vc0, sv0;
        hs0 = hsCount; err0 = errCount; ovf0 = ovfCount; vc0 = validCycles; sv0 = stableViol;
        cmdReady = 1'b0;
        sendString("R 00ff", 10);
        sendByte(8'h0D, 0);
        repeat (20) @(posedge clk);
        #1;
        checks++; if (cmdValid !== 1'b1) begin errors++; $display("[TB] FAIL read_held: got %0b want 1", cmdValid); end
        cmdReady = 1'b1;
        @(posedge clk); #1;
        checks++; if (cmdValid !== 1'b0) begin errors++; $display("[TB] FAIL read_release: got %0b want 0", cmdValid); end
        checks++; if (validCycles - vc0 !== 21) begin errors++; $display("[TB] FAIL read_valid_cycles: got %0d want 21", validCycles - vc0); end
        checks++; if (hsCount - hs0 !== 1) begin errors++; $display("[TB] FAIL read_hs: got %0d want 1", hsCount - hs0); end
        checks++; if (hsWrite !== 1'b0 || hsAddr !== 16'h00FF || hsWdata !== 32'h0) begin errors++; $display("[TB] FAIL read_fields: got %0b/%h/%h want 0/00ff/0", hsWrite, hsAddr, hsWdata); end
        checks++; if (stableViol - sv0 !== 0) begin errors++; $display("[TB] FAIL read_stable: got %0d changes want 0", stableViol - sv0); end
        sendByte(8'h0A, 10);
        checks++; if (errCount - err0 !== 0 || ovfCount - ovf0 !== 0) begin errors++; $display("[TB] FAIL read_trailing_lf: got err=%0d ovf=%0d want 0/0", errCount - err0, ovfCount - ovf0); end
    endtask

    // Too many address digits is discarded with a single error, then a short read works
    task automatic test_digit_limit;
        int hs0, err0;
        hs0 = hsCount; err0 = errCount;
        cmdReady = 1'b1;
        sendString("W 12345 1\n", 10);
        checks++; if (errCount - err0 !== 1 || hsCount - hs0 !== 0) begin errors++; $display("[TB] FAIL limit_err: got err=%0d hs=%0d want 1/0", errCount - err0, hsCount - hs0); end
        sendString("R 7\n", 10);
        checks++; if (hsCount - hs0 !== 1 || hsAddr !== 16'h0007 || hsWrite !== 1'b0) begin errors++; $display("[TB] FAIL limit_next: got hs=%0d addr=%h want 1/0007", hsCount - hs0, hsAddr); end
    endtask

    // Malformed lines each produce exactly one error and no request
    task automatic test_malformed;
        int hs0, err0;
        hs0 = hsCount; err0 = errCount;
        cmdReady = 1'b1;
        sendString("X 10\n", 10);
        checks++; if (errCount - err0 !== 1) begin errors++; $display("[TB] FAIL bad_cmd: got %0d want 1", errCount - err0); end
        sendString("W 10\n", 10);
        checks++; if (errCount - err0 !== 2) begin errors++; $display("[TB] FAIL write_no_data: got %0d want 2", errCount - err0); end
        sendString("R\n", 10);
        checks++; if (errCount - err0 !== 3) begin errors++; $display("[TB] FAIL read_no_addr: got %0d want 3", errCount - err0); end
        sendString("R 1G\n", 10);
        checks++; if (errCount - err0 !== 4) begin errors++; $display("[TB] FAIL bad_digit: got %0d want 4", errCount - err0); end
        sendString("\n \r", 10);
        checks++; if (errCount - err0 !== 4 || hsCount - hs0 !== 0) begin errors++; $display("[TB] FAIL blank_lines: got err=%0d hs=%0d want 4/0", errCount - err0, hsCount - hs0); end
    endtask

    // Byte arriving while a request is pending is dropped with an overflow pulse
    task automatic test_overflow;
        int hs0, err0, ovf0, wait0;
        hs0 = hsCount; err0 = errCount; ovf0 = ovfCount;
        cmdReady = 1'b0;
        sendString("R 5\n", 10);
        sendByte(8'h41, 10);
        checks++; if (ovfCount - ovf0 !== 1 || errCount - err0 !== 0) begin errors++; $display("[TB] FAIL ovf_pulse: got ovf=%0d err=%0d want 1/0", ovfCount - ovf0, errCount - err0); end
        checks++; if (cmdValid !== 1'b1 || cmdAddr !== 16'h0005) begin errors++; $display("[TB] FAIL ovf_held: got %0b/%h want 1/0005", cmdValid, cmdAddr); end
        cmdReady = 1'b1;
        wait0 = 0;
        while (cmdValid === 1'b1 && wait0 < 20) begin
            @(posedge clk); #1;
            wait0++;
        end
        checks++; if (cmdValid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_release_timeout: got %0b want 0", cmdValid); end
        checks++; if (hsCount - hs0 !== 1 || hsAddr !== 16'h0005) begin errors++; $display("[TB] FAIL ovf_hs: got hs=%0d addr=%h want 1/0005", hsCount - hs0, hsAddr); end
        repeat (5) @(posedge clk);
        #1;
        sendString("R 6\n", 10);
        checks++; if (hsCount - hs0 !== 2 || hsAddr !== 16'h0006 || errCount - err0 !== 0) begin errors++; $display("[TB] FAIL ovf_next: got hs=%0d addr=%h err=%0d want 2/0006/0", hsCount - hs0, hsAddr, errCount - err0); end
    endtask

    // Reset mid-line and with a request pending, then normal parsing resumes
    task automatic test_reset_mid;
        int hs0, err0;
        cmdReady = 1'b1;
        sendString("W 12 ", 10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({cmdValid, cmdWrite, errPulse, ovfPulse} !== 4'b0 || cmdAddr !== 16'h0) begin errors++; $display("[TB] FAIL rst_midline: got %b/%h want 0000/0000", {cmdValid, cmdWrite, errPulse, ovfPulse}, cmdAddr); end
        hs0 = hsCount; err0 = errCount;
        cmdReady = 1'b0;
        sendString("R 3\n", 10);
        checks++; if (cmdValid !== 1'b1 || cmdAddr !== 16'h0003 || errCount - err0 !== 0) begin errors++; $display("[TB] FAIL rst_after_line: got %0b/%h err=%0d want 1/0003/0", cmdValid, cmdAddr, errCount - err0); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (cmdValid !== 1'b0 || cmdAddr !== 16'h0 || cmdWdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_pending: got %0b/%h/%h want 0/0000/0", cmdValid, cmdAddr, cmdWdata); end
        cmdReady = 1'b1;
        sendString("R 3\n", 10);
        checks++; if (hsCount - hs0 !== 1 || hsAddr !== 16'h0003 || errCount - err0 !== 0) begin errors++; $display("[TB] FAIL rst_resume: got hs=%0d addr=%h err=%0d want 1/0003/0", hsCount - hs0, hsAddr, errCount - err0); end
    endtask

    // Next line starts two cycles after the terminator, the earliest accepted point
    task automatic test_back_to_back;
        int hs0, err0, ovf0;
        hs0 = hsCount; err0 = errCount; ovf0 = ovfCount;
        cmdReady = 1'b1;
        sendString("R 1", 0);
        sendByte(8'h0A, 1);
        sendString("W 2 c", 0);
        sendByte(8'h0D, 5);
        checks++; if (hsCount - hs0 !== 2) begin errors++; $display("[TB] FAIL b2b_count: got %0d want 2", hsCount - hs0); end
        checks++; if (hsAddr !== 16'h0002 || hsWdata !== 32'hC || hsWrite !== 1'b1) begin errors++; $display("[TB] FAIL b2b_fields: got %h/%h/%0b want 0002/0000000c/1", hsAddr, hsWdata, hsWrite); end
        checks++; if (ovfCount - ovf0 !== 0 || errCount - err0 !== 0) begin errors++; $display("[TB] FAIL b2b_flags: got ovf=%0d err=%0d want 0/0", ovfCount - ovf0, errCount - err0); end
    endtask

    // Run every scenario in order and report
    initial begin
        $display("[TB] start");
        test_reset();
        test_write();
        test_read_hold();
        test_digit_limit();
        test_malformed();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
